// File: rtl/ccff_chain_loader_pkg.sv
// ============================================================================
// Module  : ccff_chain_loader_pkg
// Purpose : Shared state encoding and width helpers for the ccff chain loader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ccff_chain_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } ccff_state_t;

   // Bit counter must be able to hold CHAIN_LEN itself, not just CHAIN_LEN-1.
   function automatic int ccff_cnt_w(input int chain_len);
      return $clog2(chain_len + 1);
   endfunction

   function automatic int ccff_idx_w(input int word_w);
      return (word_w > 1) ? $clog2(word_w) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ccff_word_serializer.sv
// ============================================================================
// Module  : ccff_word_serializer
// Purpose : Word shift register and bit index; presents bit 0 first.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ccff_word_serializer
   import ccff_chain_loader_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int IDX_W  = ccff_idx_w(WORD_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] data,
   output logic              serial_bit,
   output logic              last_bit,
   output logic [IDX_W-1:0]  bit_idx
);

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WORD_W - 1);

   logic [WORD_W-1:0] r_shreg;
   logic [IDX_W-1:0]  r_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg <= '0;
         r_idx   <= '0;
      end else if (load) begin
         r_shreg <= data;
         r_idx   <= '0;
      end else if (shift) begin
         r_shreg <= r_shreg >> 1;
         r_idx   <= r_idx + 1'b1;
      end
   end

   assign serial_bit = r_shreg[0];
   assign last_bit   = (r_idx == c_last_idx);
   assign bit_idx    = r_idx;

endmodule

`default_nettype wire

// File: rtl/ccff_chain_loader.sv
// ============================================================================
// Module  : ccff_chain_loader
// Purpose : Serialises bitstream words onto a ccff chain with a gated shift
//           enable; optional tail readback under CCFF_READBACK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ccff_chain_loader
   import ccff_chain_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 5,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = ccff_cnt_w(CHAIN_LEN)
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              ccff_clk_en,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bits_loaded
`ifdef CCFF_READBACK_EN
   ,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid
`endif
);

   localparam int              IDX_W      = ccff_idx_w(WORD_W);
   localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(CHAIN_LEN - 1);

   ccff_state_t      r_state;
   ccff_state_t      w_next;
   logic [CNT_W-1:0] r_bits;
   logic             w_shift;
   logic             w_load;
   logic             w_word_last;
   logic             w_chain_last;
   logic             w_serial_bit;
   logic [IDX_W-1:0] w_bit_idx;

   assign w_shift      = (r_state == ST_SHIFT);
   assign w_load       = (r_state == ST_LOAD) && word_valid;
   assign w_chain_last = w_shift && (r_bits == c_last_bit);

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Chain-full wins over word-end so the final word's surplus bits are dropped.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = ST_LOAD;
         ST_LOAD:  if (word_valid) w_next = ST_SHIFT;
         ST_SHIFT: begin
            if (w_chain_last) begin
               w_next = ST_DONE;
            end else if (w_word_last) begin
               w_next = ST_LOAD;
            end
         end
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         r_bits <= '0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_bits <= '0;
      end else if (w_shift) begin
         r_bits <= r_bits + 1'b1;
      end
   end

   ccff_word_serializer #(
      .WORD_W (WORD_W),
      .IDX_W  (IDX_W)
   ) u_serializer (
      .clk        (prog_clk),
      .rst        (prog_reset),
      .load       (w_load),
      .shift      (w_shift),
      .data       (word_data),
      .serial_bit (w_serial_bit),
      .last_bit   (w_word_last),
      .bit_idx    (w_bit_idx)
   );

   assign word_ready  = (r_state == ST_LOAD);
   assign ccff_clk_en = w_shift;
   assign ccff_head   = w_serial_bit;
   assign busy        = (r_state != ST_IDLE);
   assign done        = (r_state == ST_DONE);
   assign bits_loaded = r_bits;

`ifdef CCFF_READBACK_EN
   logic [WORD_W-1:0] r_rb_acc;
   logic [WORD_W-1:0] w_rb_word;

   // Tail is sampled before the shift edge, so it returns the old chain contents.
   always_comb begin
      w_rb_word            = r_rb_acc;
      w_rb_word[w_bit_idx] = ccff_tail;
   end

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         r_rb_acc <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (w_shift) begin
            if (w_word_last || w_chain_last) begin
               rb_data  <= w_rb_word;
               rb_valid <= 1'b1;
               r_rb_acc <= '0;
            end else begin
               r_rb_acc <= w_rb_word;
            end
         end
      end
   end
`else
   logic [IDX_W:0] w_unused_tail;
   assign w_unused_tail = {ccff_tail, w_bit_idx};
`endif

endmodule

`default_nettype wire
